// File: rtl/jtag_dr_chain_if.sv
// jtag_dr_chain_if: serial and parallel signals between the TAP side and
// the JTAG register chain. Clock and reset stay plain ports on the chain.
interface jtag_dr_chain_if #(
  parameter int IR_W  = 4,
  parameter int DBG_W = 32
);
  logic             TDI;
  logic [3:0]       state;
  logic [DBG_W-1:0] dbg_rdata;
  logic             TDO;
  logic             tdo_en;
  logic [IR_W-1:0]  ir;
  logic [DBG_W-1:0] dbg_wdata;
  logic             dbg_wr;

  // TAP / debug side: drives state, TDI and capture data, observes the rest
  modport master (
    output TDI, state, dbg_rdata,
    input  TDO, tdo_en, ir, dbg_wdata, dbg_wr
  );

  // register chain side
  modport slave (
    input  TDI, state, dbg_rdata,
    output TDO, tdo_en, ir, dbg_wdata, dbg_wr
  );
endinterface

// File: rtl/jtag_dr_chain.sv
// jtag_dr_chain: instruction register plus BYPASS / IDCODE / debug data
// registers, sequenced by the 4-bit TAP state.
// Optional feature macro JTAG_IDCODE_EN: when defined, the IDCODE register
// exists, code 1 selects it and ir resets to 1. When undefined, code 1 falls
// to BYPASS and ir resets to all ones.
module jtag_dr_chain #(
  parameter int          IR_W       = 4,
  parameter int          DBG_W      = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic           TCK,
  input  logic           TRST,
  jtag_dr_chain_if.slave bus
);

  localparam logic [3:0] ST_TLR      = 4'h0;
  localparam logic [3:0] ST_CAP_DR   = 4'h3;
  localparam logic [3:0] ST_SHIFT_DR = 4'h4;
  localparam logic [3:0] ST_UPD_DR   = 4'h8;
  localparam logic [3:0] ST_CAP_IR   = 4'hA;
  localparam logic [3:0] ST_SHIFT_IR = 4'hB;
  localparam logic [3:0] ST_UPD_IR   = 4'hF;

  localparam logic [IR_W-1:0] IR_DBG    = IR_W'(8);
  localparam logic [IR_W-1:0] IR_BYPASS = {IR_W{1'b1}};

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_RESET  = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET  = IR_BYPASS;
`endif

  logic [IR_W-1:0]  r_ir;
  logic [IR_W-1:0]  r_ir_shift;
  logic             r_bypass;
  logic [DBG_W-1:0] r_dbg_sr;
  logic [DBG_W-1:0] r_dbg_wdata;
  logic             r_dbg_wr;

  logic             w_sel_dbg;
  logic             w_sel_idcode;
  logic             w_sel_bypass;
  logic             w_idcode_lsb;
  logic             w_tdo;

  assign w_sel_dbg    = (r_ir == IR_DBG);
  assign w_sel_bypass = !w_sel_dbg && !w_sel_idcode;

`ifdef JTAG_IDCODE_EN
  logic [31:0] r_idcode_sr;

  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_idcode_lsb = r_idcode_sr[0];

  // IDCODE register: capture the fixed ID, shift when selected
  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_idcode_sr <= '0;
    end else if (w_sel_idcode) begin
      if (bus.state == ST_CAP_DR)
        r_idcode_sr <= IDCODE_VAL;
      else if (bus.state == ST_SHIFT_DR)
        r_idcode_sr <= {bus.TDI, r_idcode_sr[31:1]};
    end
  end
`else
  logic w_unused_idcode;

  // the ID value has no register to live in without the feature
  assign w_unused_idcode = ^IDCODE_VAL;
  assign w_sel_idcode    = 1'b0;
  assign w_idcode_lsb    = 1'b0;
`endif

  // IR, BYPASS and debug data register sequencing; dbg_wr defaults low so
  // it is a single-edge pulse after each debug update
  always_ff @(posedge TCK) begin
    r_dbg_wr <= 1'b0;
    if (TRST) begin
      r_ir        <= IR_RESET;
      r_ir_shift  <= '0;
      r_bypass    <= 1'b0;
      r_dbg_sr    <= '0;
      r_dbg_wdata <= '0;
    end else begin
      case (bus.state)
        ST_TLR:      r_ir       <= IR_RESET;
        ST_CAP_IR:   r_ir_shift <= IR_W'(1);
        ST_SHIFT_IR: r_ir_shift <= {bus.TDI, r_ir_shift[IR_W-1:1]};
        ST_UPD_IR:   r_ir       <= r_ir_shift;
        ST_CAP_DR: begin
          if (w_sel_bypass) r_bypass <= 1'b0;
          if (w_sel_dbg)    r_dbg_sr <= bus.dbg_rdata;
        end
        ST_SHIFT_DR: begin
          if (w_sel_bypass) r_bypass <= bus.TDI;
          if (w_sel_dbg)    r_dbg_sr <= {bus.TDI, r_dbg_sr[DBG_W-1:1]};
        end
        ST_UPD_DR: begin
          if (w_sel_dbg) begin
            r_dbg_wdata <= r_dbg_sr;
            r_dbg_wr    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // serial output mux: LSB of whichever register is shifting
  always_comb begin
    w_tdo = 1'b0;
    case (bus.state)
      ST_SHIFT_IR: w_tdo = r_ir_shift[0];
      ST_SHIFT_DR: begin
        if (w_sel_dbg)         w_tdo = r_dbg_sr[0];
        else if (w_sel_idcode) w_tdo = w_idcode_lsb;
        else                   w_tdo = r_bypass;
      end
      default: ;
    endcase
  end

  assign bus.TDO       = w_tdo;
  assign bus.tdo_en    = (bus.state == ST_SHIFT_IR) || (bus.state == ST_SHIFT_DR);
  assign bus.ir        = r_ir;
  assign bus.dbg_wdata = r_dbg_wdata;
  assign bus.dbg_wr    = r_dbg_wr;

endmodule
